ps2_move_decoder: RTL and testbench
===================================

Name: ps2_move_decoder

Overview:
- Converts PS/2 keyboard traffic into the 4-bit per-player move vectors consumed by the game core (player_1_move_i / player_2_move_i).
- Player 1 uses W/S/A/D; player 2 uses the arrow keys. Each output bit reflects the current held state of one key.
- Contains a PS/2 frame receiver feeding a make/break scancode decoder.
- Sits between the keyboard pins and game_top; runs on the pixel clock.

Parameters:
- TIMEOUT_CYCLES, 25000: clk_i cycles without a PS/2 clock falling edge mid-frame before the frame is abandoned (1 ms at 25 MHz).
- SYNC_STAGES, 2: synchronizer depth on ps2_clk_i and ps2_data_i; minimum 2.

Ports:
- clk_i  in  1  system/pixel clock
- reset_i  in  1  synchronous reset, active-low
- ps2_clk_i  in  1  raw PS/2 clock pin, asynchronous
- ps2_data_i  in  1  raw PS/2 data pin, asynchronous
- player_1_move_o  out  4  bit0 up(W), bit1 down(S), bit2 left(A), bit3 right(D)
- player_2_move_o  out  4  bit0 up(E0 75), bit1 down(E0 72), bit2 left(E0 6B), bit3 right(E0 74)
- scan_valid_o  out  1  one-cycle pulse; a good frame was received
- scan_code_o  out  8  last good byte; held until the next good frame
- frame_error_o  out  1  one-cycle pulse on a parity, start, stop or timeout error

Behaviour:
- Reset (reset_i=0 sampled at a clk_i edge):
  - All outputs 0; receiver in IDLE; decoder flags ext and brk cleared.
  - Synchronizer flops preset to 1 (idle bus).
  - Reset mid-frame discards the partial byte.
- Edge detect: a falling edge is synced ps2_clk going 1->0 between consecutive cycles. All sampling happens on that cycle using synced data.
- Receiver FSM:
  - IDLE -> DATA when a falling edge sees data=0. If the edge sees data=1, stay in IDLE with no error.
  - DATA: shift bits in LSB first, 8 edges, 3-bit counter -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: on the edge, if stop=1 and (^data ^ parity)=1 (odd parity), pulse scan_valid_o and load scan_code_o the next cycle. Otherwise pulse frame_error_o. Return to IDLE in either case.
- Timeout: a 15-bit counter clears on every falling edge and counts while not in IDLE. At TIMEOUT_CYCLES-1, pulse frame_error_o and go to IDLE.
- Decoder, acting on the scan_valid_o cycle:
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte: look up (ext, byte). If mapped, the bit is set when brk=0 and cleared when brk=1. Then clear ext and brk. Unmapped bytes (including E1, and 1D-class codes arriving with ext=1) only clear the flags.
- Latency: stop-bit edge cycle N -> scan_valid_o high on N+1 -> move bits updated on N+2. Pin-to-edge-detect adds SYNC_STAGES+1 cycles.
- Opposing keys held together (e.g. W and S): both bits read 1. No arbitration here.
- Setting an already-set bit, or clearing an already-clear bit, is a no-op.
- A frame error does not alter ext, brk or move state.
- Typematic repeats of a make code leave the bit at 1.

Optional Feature:
- Macro MOVE_DECODER_SHOOT_EN.
- Defined:
  - Adds ports player_1_shoot_o (1, Space 29) and player_2_shoot_o (1, right Ctrl E0 14), both reset 0.
  - Both follow the same held-state make/break rules as the move bits.
  - Intended for the player_rgb shoot inputs.
- Undefined: these ports are absent; 29 and E0 14 are unmapped.

Decomposition:
- Package ps2_move_pkg:
  - Move bit indices (MOVE_UP=0, MOVE_DOWN=1, MOVE_LEFT=2, MOVE_RIGHT=3).
  - Scancode constants (SC_EXT=E0, SC_BREAK=F0, SC_W=1D, SC_S=1B, SC_A=1C, SC_D=23, SC_UP=75, SC_DOWN=72, SC_LEFT=6B, SC_RIGHT=74, SC_SPACE=29, SC_RCTRL=14).
  - Receiver state enum.
- Sub-module ps2_rx: synchronizer, edge detect, frame FSM, timeout, valid/error pulses.
- The top level holds the decoder flags and key-state registers.

Test Plan:
- Frame 1D (make W) -> scan_code_o=1D, one scan_valid_o pulse, player_1_move_o=4'b0001 two cycles after the stop edge; then F0,1D -> 4'b0000.
- E0,74 then 23 (P2 right, P1 D) -> player_2_move_o=4'b1000, player_1_move_o=4'b1000; then E0,F0,74 -> player_2_move_o=0, P1 unchanged.
- Frame 1D with even parity -> frame_error_o pulse, no scan_valid_o, move unchanged; the next valid 1B frame -> player_1_move_o=4'b0010.
- Stop PS/2 clock after 4 data bits and wait TIMEOUT_CYCLES -> one frame_error_o pulse, FSM in IDLE; the next full 1C frame decodes (bit2 set).
- Hold W and S (1D,1B) -> 4'b0011; assert reset_i=0 mid-frame of the next byte -> all outputs 0; after release, 23 -> 4'b1000.
- With MOVE_DECODER_SHOOT_EN: 29 -> player_1_shoot_o=1; E0,14 -> player_2_shoot_o=1; F0,29 -> player_1_shoot_o=0.

Source files
------------

// File: rtl/ps2_move_decoder_pkg.sv
// Shared constants, receiver state type and key lookup for the PS/2 move decoder.
// MOVE_DECODER_SHOOT_EN adds the two shoot keys to the key map.
package ps2_move_pkg;

    localparam int MOVE_UP    = 0;
    localparam int MOVE_DOWN  = 1;
    localparam int MOVE_LEFT  = 2;
    localparam int MOVE_RIGHT = 3;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_RCTRL = 8'h14;

    // Key-state layout: [3:0] player 1 moves, [7:4] player 2 moves, [9:8] shoot keys.
`ifdef MOVE_DECODER_SHOOT_EN
    localparam int NUM_KEYS = 10;
`else
    localparam int NUM_KEYS = 8;
`endif

    typedef logic [NUM_KEYS-1:0] key_mask_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // One-hot mask of the key addressed by (ext, code); zero when unmapped.
    function automatic key_mask_t key_mask(input logic ext, input logic [7:0] code);
        key_mask_t m;
        m = '0;
        case ({ext, code})
            {1'b0, SC_W}:     m = key_mask_t'(1) << MOVE_UP;
            {1'b0, SC_S}:     m = key_mask_t'(1) << MOVE_DOWN;
            {1'b0, SC_A}:     m = key_mask_t'(1) << MOVE_LEFT;
            {1'b0, SC_D}:     m = key_mask_t'(1) << MOVE_RIGHT;
            {1'b1, SC_UP}:    m = key_mask_t'(1) << (4 + MOVE_UP);
            {1'b1, SC_DOWN}:  m = key_mask_t'(1) << (4 + MOVE_DOWN);
            {1'b1, SC_LEFT}:  m = key_mask_t'(1) << (4 + MOVE_LEFT);
            {1'b1, SC_RIGHT}: m = key_mask_t'(1) << (4 + MOVE_RIGHT);
`ifdef MOVE_DECODER_SHOOT_EN
            {1'b0, SC_SPACE}: m = key_mask_t'(1) << 8;
            {1'b1, SC_RCTRL}: m = key_mask_t'(1) << 9;
`endif
            default:          m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_move_decoder_if.sv
// Keyboard pins and decoded outputs of the PS/2 move decoder.
// MOVE_DECODER_SHOOT_EN adds the per-player shoot signals.
interface ps2_move_decoder_if;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic [3:0] player_1_move_o;
    logic [3:0] player_2_move_o;
    logic       scan_valid_o;
    logic [7:0] scan_code_o;
    logic       frame_error_o;
`ifdef MOVE_DECODER_SHOOT_EN
    logic       player_1_shoot_o;
    logic       player_2_shoot_o;

    modport master (
        output ps2_clk_i, ps2_data_i,
        input  player_1_move_o, player_2_move_o, scan_valid_o, scan_code_o,
               frame_error_o, player_1_shoot_o, player_2_shoot_o
    );
    modport slave (
        input  ps2_clk_i, ps2_data_i,
        output player_1_move_o, player_2_move_o, scan_valid_o, scan_code_o,
               frame_error_o, player_1_shoot_o, player_2_shoot_o
    );
`else
    modport master (
        output ps2_clk_i, ps2_data_i,
        input  player_1_move_o, player_2_move_o, scan_valid_o, scan_code_o,
               frame_error_o
    );
    modport slave (
        input  ps2_clk_i, ps2_data_i,
        output player_1_move_o, player_2_move_o, scan_valid_o, scan_code_o,
               frame_error_o
    );
`endif
endinterface

// File: rtl/ps2_move_decoder_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame FSM,
// inactivity timeout, and registered good-byte / error pulses.
module ps2_rx
    import ps2_move_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_valid,
    output logic [7:0] o_code,
    output logic       o_error
);

    localparam int TMO_W = 15;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    rx_state_e              r_state;
    rx_state_e              w_next;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_parity;
    logic [TMO_W-1:0]       r_tmo;
    logic                   r_valid;
    logic                   r_error;
    logic [7:0]             r_code;
    logic                   w_fall;
    logic                   w_bit;
    logic                   w_tmo_hit;
    logic                   w_good;
    logic                   w_err;

    // Synchronizers idle high so reset never fabricates a falling edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_bit     = r_dat_sync[SYNC_STAGES-1];
    assign w_tmo_hit = (r_state != RX_IDLE) && !w_fall &&
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= RX_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_tmo_hit) begin
            w_next = RX_IDLE;
        end else if (w_fall) begin
            case (r_state)
                RX_IDLE:   if (!w_bit) w_next = RX_DATA;
                RX_DATA:   if (r_bit_cnt == 3'd7) w_next = RX_PARITY;
                RX_PARITY: w_next = RX_STOP;
                RX_STOP:   w_next = RX_IDLE;
                default:   w_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        w_good = 1'b0;
        w_err  = w_tmo_hit;
        if (w_fall && (r_state == RX_STOP)) begin
            if (w_bit && ((^r_shift) ^ r_parity)) w_good = 1'b1;
            else                                  w_err  = 1'b1;
        end
    end

    // Frame datapath: bit counter, LSB-first shifter, parity capture, timeout.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
            r_tmo     <= '0;
        end else begin
            if (r_state == RX_IDLE)              r_bit_cnt <= '0;
            else if (w_fall && r_state == RX_DATA) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_state == RX_IDLE || w_fall)    r_tmo <= '0;
            else                                 r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_fall && r_state == RX_DATA)   r_shift  <= {w_bit, r_shift[7:1]};
        if (w_fall && r_state == RX_PARITY) r_parity <= w_bit;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_code  <= '0;
        end else begin
            r_valid <= w_good;
            r_error <= w_err;
            if (w_good) r_code <= r_shift;
        end
    end

    assign o_valid = r_valid;
    assign o_code  = r_code;
    assign o_error = r_error;

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard to per-player move vectors: ps2_rx plus make/break decoder.
// MOVE_DECODER_SHOOT_EN adds player_1_shoot_o (Space) and player_2_shoot_o (right Ctrl).
module ps2_move_decoder
    import ps2_move_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    ps2_move_decoder_if.slave    bus
);

    logic       w_valid;
    logic [7:0] w_code;
    logic       w_error;
    logic       r_ext;
    logic       r_brk;
    key_mask_t  r_keys;
    key_mask_t  w_mask;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .i_clk      (clk_i),
        .i_rst_n    (reset_i),
        .i_ps2_clk  (bus.ps2_clk_i),
        .i_ps2_data (bus.ps2_data_i),
        .o_valid    (w_valid),
        .o_code     (w_code),
        .o_error    (w_error)
    );

    assign w_mask = key_mask(r_ext, w_code);

    // Prefix bytes only arm flags; any other byte consumes them, mapped or not.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_keys <= '0;
        end else if (w_valid) begin
            if (w_code == SC_EXT) begin
                r_ext <= 1'b1;
            end else if (w_code == SC_BREAK) begin
                r_brk <= 1'b1;
            end else begin
                r_keys <= r_brk ? (r_keys & ~w_mask) : (r_keys | w_mask);
                r_ext  <= 1'b0;
                r_brk  <= 1'b0;
            end
        end
    end

    assign bus.player_1_move_o = r_keys[3:0];
    assign bus.player_2_move_o = r_keys[7:4];
    assign bus.scan_valid_o    = w_valid;
    assign bus.scan_code_o     = w_code;
    assign bus.frame_error_o   = w_error;
`ifdef MOVE_DECODER_SHOOT_EN
    assign bus.player_1_shoot_o = r_keys[8];
    assign bus.player_2_shoot_o = r_keys[9];
`endif

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Scoreboard bench for ps2_move_decoder: directed and random PS/2 keystrokes
// against a held-key reference model.
module tb_ps2_move_decoder;

    localparam int TMO  = 400;
    localparam int HALF = 4;

    typedef struct {
        bit         err;
        logic [7:0] code;
        logic [9:0] pre;
        logic [9:0] post;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ps2_move_decoder_if bus();

    ps2_move_decoder #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus)
    );

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         keymap[int];
    logic [9:0] held;
    bit         m_ext, m_brk;

    function automatic logic [9:0] dut_keys();
`ifdef MOVE_DECODER_SHOOT_EN
        return {bus.player_2_shoot_o, bus.player_1_shoot_o, bus.player_2_move_o, bus.player_1_move_o};
`else
        return {2'b00, bus.player_2_move_o, bus.player_1_move_o};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: held-key set driven by prefix-then-code keystroke rules.
    function automatic void model_byte(input logic [7:0] b);
        exp_t e;
        int   k;
        e.err  = 1'b0;
        e.code = b;
        e.pre  = held;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            k = (m_ext ? 256 : 0) + int'(b);
            if (keymap.exists(k)) held[keymap[k]] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        e.post = held;
        sb.push_back(e);
    endfunction

    function automatic void model_err();
        exp_t e;
        e.err  = 1'b1;
        e.code = 8'h00;
        e.pre  = held;
        e.post = held;
        sb.push_back(e);
    endfunction

    // Monitor: pops an expectation for every valid/error pulse.
    initial begin
        exp_t e, pe;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("move_update", dut_keys(), pe.post);
                    check("code_hold", bus.scan_code_o, pe.code);
                    pend = 1'b0;
                end
                if (bus.scan_valid_o || bus.frame_error_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", {bus.scan_valid_o, bus.frame_error_o}, 0);
                    end else begin
                        e = sb.pop_front();
                        check("error_pulse", bus.frame_error_o, e.err);
                        check("valid_pulse", bus.scan_valid_o, !e.err);
                        if (!e.err) begin
                            check("scan_code", bus.scan_code_o, e.code);
                            check("move_before_update", dut_keys(), e.pre);
                            pe   = e;
                            pend = 1'b1;
                        end else begin
                            check("move_on_error", dut_keys(), e.post);
                        end
                    end
                end
            end
        end
    end

    task automatic ps2_bit(input bit v);
        bus.ps2_data_i = v;
        repeat (HALF) @(posedge clk);
        bus.ps2_clk_i = 1'b0;
        repeat (HALF) @(posedge clk);
        bus.ps2_clk_i = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        bus.ps2_data_i = 1'b1;
        repeat (2 * HALF) @(posedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_raw(b, 1'b0, 1'b0, 11);
        wait_drain(50);
    endtask

    task automatic send_bad(input logic [7:0] b, input bit bp, input bit bs);
        model_err();
        send_raw(b, bp, bs, 11);
        wait_drain(50);
    endtask

    task automatic key(input logic [7:0] code, input bit ext, input bit brk);
        if (ext) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_byte(code);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [12];
        bit         pext [12];
        int         r;

        keymap[32'h01D] = 0; keymap[32'h01B] = 1; keymap[32'h01C] = 2; keymap[32'h023] = 3;
        keymap[32'h175] = 4; keymap[32'h172] = 5; keymap[32'h16B] = 6; keymap[32'h174] = 7;
`ifdef MOVE_DECODER_SHOOT_EN
        keymap[32'h029] = 8; keymap[32'h114] = 9;
`endif
        pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'hE1, 8'h1D};
        pext = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1};
        held = '0; m_ext = 0; m_brk = 0;

        bus.ps2_clk_i  = 1'b1;
        bus.ps2_data_i = 1'b1;
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_state", {dut_keys(), bus.scan_valid_o, bus.scan_code_o, bus.frame_error_o}, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        send_byte(8'h1D);
        check("w_make", bus.player_1_move_o, 4'b0001);
        key(8'h1D, 0, 1);
        check("w_break", bus.player_1_move_o, 4'b0000);

        key(8'h74, 1, 0);
        key(8'h23, 0, 0);
        check("p2_right", bus.player_2_move_o, 4'b1000);
        check("p1_right", bus.player_1_move_o, 4'b1000);
        key(8'h74, 1, 1);
        check("p2_release", bus.player_2_move_o, 4'b0000);
        check("p1_kept", bus.player_1_move_o, 4'b1000);
        key(8'h23, 0, 1);

        send_bad(8'h1D, 1'b1, 1'b0);
        check("parity_err_nochange", bus.player_1_move_o, 4'b0000);
        send_byte(8'h1B);
        check("after_parity_err", bus.player_1_move_o, 4'b0010);
        send_bad(8'h1C, 1'b0, 1'b1);
        key(8'h1B, 0, 1);

        model_err();
        send_raw(8'h1D, 1'b0, 1'b0, 5);
        wait_drain(TMO + 100);
        send_byte(8'h1C);
        check("after_timeout", bus.player_1_move_o, 4'b0100);
        key(8'h1C, 0, 1);

        key(8'h1D, 0, 0); key(8'h1D, 0, 0);
        key(8'h1B, 0, 0);
        check("w_and_s", bus.player_1_move_o, 4'b0011);
        key(8'h1D, 1, 0);
        key(8'hE1, 0, 0);
        check("unmapped_ext_1d", bus.player_1_move_o, 4'b0011);
        send_raw(8'h23, 1'b0, 1'b0, 6);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_midframe", {dut_keys(), bus.scan_valid_o, bus.scan_code_o, bus.frame_error_o}, 0);
        sb.delete();
        held = '0; m_ext = 0; m_brk = 0;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        send_byte(8'h23);
        check("after_reset", bus.player_1_move_o, 4'b1000);

`ifdef MOVE_DECODER_SHOOT_EN
        key(8'h29, 0, 0);
        check("p1_shoot", bus.player_1_shoot_o, 1'b1);
        key(8'h14, 1, 0);
        check("p2_shoot", bus.player_2_shoot_o, 1'b1);
        key(8'h29, 0, 1);
        check("p1_shoot_rel", bus.player_1_shoot_o, 1'b0);
`endif

        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 15);
            if (r < 12) key(pool[r], pext[r], $urandom_range(0, 1) == 1);
            else if (r == 12) send_bad(8'($urandom), 1'b1, 1'b0);
            else if (r == 13) send_bad(8'($urandom), 1'b0, 1'b1);
            else send_byte(8'($urandom));
        end

        repeat (10) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
